// File: rtl/fsm_step_sequencer_pkg.sv
// fsm_step_sequencer_pkg
//   Shared encodings for the FSM processor sequencer and its counter-reset
//   decoder: the 3-bit state encoding and the 2-bit opcode encoding.
//   No ports (package).
package fsm_step_sequencer_pkg;

  // State encoding is fixed because the external counter-reset decoder
  // compares against these exact values.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_CMP    = 3'd4,
    S_WAIT   = 3'd5,
    S_BRANCH = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_LOOP  = 2'b01;
  localparam logic [1:0] OP_CMPBR = 2'b10;
  localparam logic [1:0] OP_HALT  = 2'b11;

  localparam logic [3:0] LOOP_MAX_DEF = 4'hF;
  localparam logic [3:0] BR_LEN_DEF   = 4'h7;

endpackage

// File: rtl/fsm_step_sequencer_if.sv
// fsm_step_sequencer_if
//   Instruction fetch handshake between the instruction source (master) and
//   the sequencer (slave).
//   instr_valid : master -> slave, opcode on instr_op is valid
//   instr_op    : master -> slave, 2-bit opcode
//   instr_ready : slave -> master, sequencer can accept an opcode
interface fsm_step_sequencer_if;
  logic       instr_valid;
  logic [1:0] instr_op;
  logic       instr_ready;

  modport master (output instr_valid, output instr_op, input instr_ready);
  modport slave  (input instr_valid, input instr_op, output instr_ready);
endinterface

// File: rtl/fsm_step_sequencer_step_count_reg.sv
// step_count_reg
//   4-bit step counter of the sequencer. Clear has priority over increment.
//   Ports: clk, rst_n (async active-low), clr (sync clear), inc (count
//   enable), count (registered value).
//   Build option COUNT_SAT_EN: when defined the counter saturates at 4'hF,
//   otherwise it wraps modulo 16.
module step_count_reg (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next count: clear, then increment, then hold.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'h0;
    end else if (inc) begin
`ifdef COUNT_SAT_EN
      if (count_q == 4'hF) begin
        count_d = count_q;
      end else begin
        count_d = count_q + 4'h1;
      end
`else
      count_d = count_q + 4'h1;
`endif
    end else begin
      count_d = count_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'h0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer
//   Sequencer core of the FSM processor: owns the state register, the step
//   count register and the opcode latch, fetches opcodes over a valid/ready
//   handshake and walks the fixed 8-state machine until HALT.
//   Ports:
//     clk, rst_n   : clock, async active-low reset
//     start        : level, leaves IDLE; must drop to leave HALT
//     instr        : fetch handshake (slave side of fsm_step_sequencer_if)
//     stall        : pauses EXEC
//     cmp          : compare flag, sampled in CMP
//     cnt_rst      : synchronous count clear from the reset decoder
//     state        : registered state
//     opcode_q     : opcode latched at the FETCH handshake
//     count        : registered step count
//     busy, done   : registered status (not IDLE/HALT, and HALT)
//   Build option COUNT_SAT_EN (see step_count_reg): saturating count.
module fsm_step_sequencer
  import fsm_step_sequencer_pkg::*;
#(
  parameter logic [3:0] LOOP_MAX = LOOP_MAX_DEF,
  parameter logic [3:0] BR_LEN   = BR_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  fsm_step_sequencer_if.slave       instr,
  input  logic                      stall,
  input  logic                      cmp,
  input  logic                      cnt_rst,
  output logic [2:0]                state,
  output logic [1:0]                opcode_q,
  output logic [3:0]                count,
  output logic                      busy,
  output logic                      done
);

  state_t     state_q;
  state_t     state_d;
  logic [1:0] opcode_d;
  logic       busy_q;
  logic       busy_d;
  logic       done_q;
  logic       done_d;
  logic       inc_s;
  logic [3:0] count_s;

  // Next-state, opcode latch and count-enable decode.
  always_comb begin
    state_d  = state_q;
    opcode_d = opcode_q;
    inc_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (instr.instr_valid) begin
          state_d  = S_DECODE;
          opcode_d = instr.instr_op;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        case (opcode_q)
          OP_NOP:   state_d = S_FETCH;
          OP_LOOP:  state_d = S_EXEC;
          OP_CMPBR: state_d = S_CMP;
          OP_HALT:  state_d = S_HALT;
          default:  state_d = S_FETCH;
        endcase
      end
      S_EXEC: begin
        inc_s = !stall;
        // Loop end wins over stall so a stalled final step still exits.
        if (count_s == LOOP_MAX) begin
          state_d = S_FETCH;
        end else if (stall) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_WAIT: begin
        if (!stall) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_CMP: begin
        if (cmp) begin
          state_d = S_BRANCH;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_BRANCH: begin
        inc_s = 1'b1;
        if (count_s == BR_LEN) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_BRANCH;
        end
      end
      S_HALT: begin
        if (!start) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_HALT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status flags are decoded from the next state so the flops line up
  // with the registered state.
  always_comb begin
    busy_d = (state_d != S_IDLE) && (state_d != S_HALT);
    done_d = (state_d == S_HALT);
  end

  // State, opcode latch and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      opcode_q <= OP_NOP;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opcode_q <= opcode_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  step_count_reg u_step_count_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_rst),
    .inc   (inc_s),
    .count (count_s)
  );

  assign instr.instr_ready = (state_q == S_FETCH);
  assign state             = state_q;
  assign count             = count_s;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// tb_fsm_step_sequencer
//   Directed self-checking bench for fsm_step_sequencer. Inputs change one
//   time unit after the rising edge; outputs are checked at the same point.
module tb_fsm_step_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stall;
  logic       cmp;
  logic       cnt_rst;
  logic [2:0] state;
  logic [1:0] opcode_q;
  logic [3:0] count;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  fsm_step_sequencer_if bus ();

  fsm_step_sequencer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .instr    (bus),
    .stall    (stall),
    .cmp      (cmp),
    .cnt_rst  (cnt_rst),
    .state    (state),
    .opcode_q (opcode_q),
    .count    (count),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sc(input string tag, input logic [2:0] st, input logic [3:0] cn);
    chk({tag, "_state"}, {5'd0, state}, {5'd0, st});
    chk({tag, "_count"}, {4'd0, count}, {4'd0, cn});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    stall    = 1'b0;
    cmp      = 1'b0;
    cnt_rst  = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_op    = 2'b00;

    // Reset values
    #1;
    chk_sc("rst", 3'd0, 4'h0);
    chk("rst_opcode", {6'd0, opcode_q}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_done", {7'd0, done}, 8'h00);
    chk("rst_ready", {7'd0, bus.instr_ready}, 8'h00);
    step();
    step();
    rst_n = 1'b1;
    step();
    chk("idle_hold", {5'd0, state}, 8'h00);

    // 1: NOP fetch round trip
    start = 1'b1;
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b00;
    step();
    chk("t1_fetch", {5'd0, state}, 8'h01);
    chk("t1_ready_fetch", {7'd0, bus.instr_ready}, 8'h01);
    chk("t1_busy", {7'd0, busy}, 8'h01);
    step();
    chk("t1_decode", {5'd0, state}, 8'h02);
    chk("t1_ready_decode", {7'd0, bus.instr_ready}, 8'h00);
    chk("t1_opcode", {6'd0, opcode_q}, 8'h00);
    step();
    chk("t1_back_fetch", {5'd0, state}, 8'h01);
    bus.instr_valid = 1'b0;
    start = 1'b0;
    step();
    chk("t1_fetch_hold", {5'd0, state}, 8'h01);

    // 2: LOOP runs 16 EXEC cycles and wraps
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b01;
    step();
    chk("t2_decode", {5'd0, state}, 8'h02);
    chk("t2_opcode", {6'd0, opcode_q}, 8'h01);
    bus.instr_valid = 1'b0;
    step();
    chk_sc("t2_exec0", 3'd3, 4'h0);
    chk("t2_ready_exec", {7'd0, bus.instr_ready}, 8'h00);
    for (int i = 1; i < 16; i++) begin
      step();
      chk_sc("t2_exec", 3'd3, i[3:0]);
    end
    step();
`ifdef COUNT_SAT_EN
    chk_sc("t2_exit", 3'd1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_sc("t6_sat_hold", 3'd1, 4'hF);
    end
`else
    chk_sc("t2_exit", 3'd1, 4'h0);
`endif
    // cnt_rst honoured outside EXEC
    cnt_rst = 1'b1;
    step();
    chk_sc("t2_clr_fetch", 3'd1, 4'h0);
    cnt_rst = 1'b0;

    // 4: stall and cnt_rst inside EXEC
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b01;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk_sc("t4_exec0", 3'd3, 4'h0);
    for (int i = 0; i < 5; i++) step();
    chk_sc("t4_exec5", 3'd3, 4'h5);
    stall = 1'b1;
    step();
    chk_sc("t4_wait", 3'd5, 4'h5);
    step();
    chk_sc("t4_wait_hold", 3'd5, 4'h5);
    stall = 1'b0;
    step();
    chk_sc("t4_resume", 3'd3, 4'h5);
    step();
    chk_sc("t4_resume_inc", 3'd3, 4'h6);
    for (int i = 0; i < 3; i++) step();
    chk_sc("t4_exec9", 3'd3, 4'h9);
    cnt_rst = 1'b1;
    step();
    chk_sc("t4_clr", 3'd3, 4'h0);
    cnt_rst = 1'b0;

    // 6: async reset mid-EXEC at count A
    for (int i = 0; i < 10; i++) step();
    chk_sc("t6_execA", 3'd3, 4'hA);
    #2;
    rst_n = 1'b0;
    #1;
    chk_sc("t6_async_rst", 3'd0, 4'h0);
    chk("t6_busy", {7'd0, busy}, 8'h00);
    rst_n = 1'b1;
    start = 1'b1;

    // 3: CMPBR taken and not taken
    step();
    chk_sc("t3_fetch", 3'd1, 4'h0);
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b10;
    cmp = 1'b1;
    step();
    chk("t3_opcode", {6'd0, opcode_q}, 8'h02);
    bus.instr_valid = 1'b0;
    step();
    chk_sc("t3_cmp", 3'd4, 4'h0);
    step();
    chk_sc("t3_branch0", 3'd6, 4'h0);
    for (int i = 1; i < 8; i++) begin
      step();
      chk_sc("t3_branch", 3'd6, i[3:0]);
    end
    step();
    chk_sc("t3_br_exit", 3'd1, 4'h8);
    cnt_rst = 1'b1;
    step();
    chk_sc("t3_clr", 3'd1, 4'h0);
    cnt_rst = 1'b0;
    bus.instr_valid = 1'b1;
    cmp = 1'b0;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk_sc("t3_cmp_nt", 3'd4, 4'h0);
    step();
    chk_sc("t3_not_taken", 3'd1, 4'h0);

    // 5: HALT holds while start high, returns to IDLE when it drops
    bus.instr_valid = 1'b1;
    bus.instr_op    = 2'b11;
    step();
    bus.instr_valid = 1'b0;
    step();
    chk("t5_halt", {5'd0, state}, 8'h07);
    chk("t5_done", {7'd0, done}, 8'h01);
    chk("t5_busy", {7'd0, busy}, 8'h00);
    step();
    chk("t5_halt_hold", {5'd0, state}, 8'h07);
    start = 1'b0;
    step();
    chk("t5_idle", {5'd0, state}, 8'h00);
    chk("t5_done_clr", {7'd0, done}, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
